mul_accum: RTL

- Downstream consumer of the combinational multiplier's full-width product.
- Accumulates a stream of signed 2*LEN-bit products into a wide accumulator under a valid/ready handshake.
- Emits one result per batch, where a batch is the run of terms ending in one marked last.
- Together with the multiplier it forms the MAC/dot-product datapath. It is sized as a generated Scrap Mechanic logic module.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_accum_if.sv | 32 +++
 rtl/mul_accum_add.sv | 26 ++
 rtl/mul_accum.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier / accumulator datapath.
// The default widths match the multiplier's 16-bit FULL_SIGNED and FULL_MIXED builds.
package mul_pkg;

    localparam int LEN_DEF     = 16;
    localparam int ACC_LEN_DEF = 40;
    localparam int CNT_LEN_DEF = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_accum_if.sv
// Product stream in, batch result out.
// The slave side is the accumulator. The master side is the producer and consumer pair.
interface mul_accum_if
    import mul_pkg::*;
#(
    parameter int LEN     = LEN_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF,
    parameter int CNT_LEN = CNT_LEN_DEF
);

    logic [2*LEN-1:0]   P;
    logic               P_VALID;
    logic               P_LAST;
    logic               P_READY;
    logic               CLR;
    logic [ACC_LEN-1:0] Y;
    logic [CNT_LEN-1:0] Y_CNT;
    logic               Y_OVF;
    logic               Y_VALID;
    logic               Y_READY;

    modport master (
        output P, P_VALID, P_LAST, CLR, Y_READY,
        input  P_READY, Y, Y_CNT, Y_OVF, Y_VALID
    );

    modport slave (
        input  P, P_VALID, P_LAST, CLR, Y_READY,
        output P_READY, Y, Y_CNT, Y_OVF, Y_VALID
    );

endinterface

// File: rtl/mul_accum_add.sv
// Combinational accumulate step: sign-extends a product and adds it to the accumulator.
// It also flags signed overflow. When clr is set, the old accumulator is treated as zero.
module mul_accum_add #(
    parameter int LEN     = 16,
    parameter int ACC_LEN = 40
) (
    input  logic [ACC_LEN-1:0] acc,
    input  logic [2*LEN-1:0]   p,
    input  logic               clr,
    output logic [ACC_LEN-1:0] sum,
    output logic               ovf
);

    logic [ACC_LEN-1:0] base_s;
    logic [ACC_LEN-1:0] p_ext_s;

    // Pick the base operand, extend the product, and add with the overflow flag.
    always_comb begin
        base_s  = clr ? {ACC_LEN{1'b0}} : acc;
        p_ext_s = ACC_LEN'($signed(p));
        sum     = base_s + p_ext_s;
        ovf     = (base_s[ACC_LEN-1] == p_ext_s[ACC_LEN-1]) &&
                  (sum[ACC_LEN-1] != base_s[ACC_LEN-1]);
    end

endmodule

// File: rtl/mul_accum.sv
// Batch accumulator for signed multiplier products, using valid/ready on both sides.
// It emits one held result per batch. A batch ends on the term marked P_LAST.
module mul_accum
    import mul_pkg::*;
#(
    parameter int LEN     = LEN_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF,
    parameter int CNT_LEN = CNT_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    mul_accum_if.slave  bus
);

    localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};

    state_t             state_r;
    logic [ACC_LEN-1:0] acc_r;
    logic [CNT_LEN-1:0] cnt_r;
    logic               ovf_r;
    logic [ACC_LEN-1:0] y_r;
    logic [CNT_LEN-1:0] y_cnt_r;
    logic               y_ovf_r;
    logic               y_valid_r;
    logic               p_ready_r;

    logic [ACC_LEN-1:0] sum_s;
    logic               add_ovf_s;
    logic [CNT_LEN-1:0] cnt_base_s;
    logic [CNT_LEN-1:0] cnt_next_s;
    logic               ovf_next_s;
    logic               p_beat_s;
    logic               y_beat_s;

    mul_accum_add #(
        .LEN     (LEN),
        .ACC_LEN (ACC_LEN)
    ) u_add (
        .acc (acc_r),
        .p   (bus.P),
        .clr (bus.CLR),
        .sum (sum_s),
        .ovf (add_ovf_s)
    );

    // Handshake beats, and the counter and overflow values that follow when CLR applies first.
    always_comb begin
        p_beat_s   = bus.P_VALID & p_ready_r;
        y_beat_s   = y_valid_r & bus.Y_READY;
        cnt_base_s = bus.CLR ? {CNT_LEN{1'b0}} : cnt_r;
        if (cnt_base_s == CNT_MAX) begin
            cnt_next_s = cnt_base_s;
        end else begin
            cnt_next_s = cnt_base_s + CNT_LEN'(1'b1);
        end
        ovf_next_s = (bus.CLR ? 1'b0 : ovf_r) | add_ovf_s;
    end

    // Batch FSM. Result registers are loaded only on the closing beat, so Y holds during HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ACCUM;
            acc_r     <= {ACC_LEN{1'b0}};
            cnt_r     <= {CNT_LEN{1'b0}};
            ovf_r     <= 1'b0;
            y_r       <= {ACC_LEN{1'b0}};
            y_cnt_r   <= {CNT_LEN{1'b0}};
            y_ovf_r   <= 1'b0;
            y_valid_r <= 1'b0;
            p_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (p_beat_s && bus.P_LAST) begin
                        y_r       <= sum_s;
                        y_cnt_r   <= cnt_next_s;
                        y_ovf_r   <= ovf_next_s;
                        y_valid_r <= 1'b1;
                        acc_r     <= {ACC_LEN{1'b0}};
                        cnt_r     <= {CNT_LEN{1'b0}};
                        ovf_r     <= 1'b0;
                        p_ready_r <= 1'b0;
                        state_r   <= HOLD;
                    end else if (p_beat_s) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_next_s;
                        ovf_r <= ovf_next_s;
                    end else if (bus.CLR) begin
                        acc_r <= {ACC_LEN{1'b0}};
                        cnt_r <= {CNT_LEN{1'b0}};
                        ovf_r <= 1'b0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                HOLD: begin
                    // CLR is ignored here, so a finished result is never discarded.
                    if (y_beat_s) begin
                        y_valid_r <= 1'b0;
                        p_ready_r <= 1'b1;
                        state_r   <= ACCUM;
                    end else begin
                        y_valid_r <= y_valid_r;
                    end
                end
                default: begin
                    state_r   <= ACCUM;
                    y_valid_r <= 1'b0;
                    p_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.P_READY = p_ready_r;
    assign bus.Y       = y_r;
    assign bus.Y_CNT   = y_cnt_r;
    assign bus.Y_OVF   = y_ovf_r;
    assign bus.Y_VALID = y_valid_r;

endmodule
